// File: rtl/ksa_pkg.sv
// Shared types and helpers for the RC4 key-scheduling and decrypt FSMs.
package ksa_pkg;

  localparam int BYTE_W        = 8;
  localparam int MEM_DEPTH     = 256;
  localparam int KEY_MAX_BYTES = 8;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_I,
    ST_WT_I,
    ST_CAP_I,
    ST_RD_J,
    ST_WT_J,
    ST_CAP_J,
    ST_WR_I,
    ST_WR_J,
    ST_FIN
  } ksa_swap_state_t;

  // key is left-aligned in 64 bits: byte 0 (the key's MSB byte) sits at [63:56]
  function automatic logic [BYTE_W-1:0] key_byte(input logic [8*KEY_MAX_BYTES-1:0] key,
                                                 input logic [2:0] idx);
    return key[63 - 8*int'(idx) -: 8];
  endfunction

endpackage

// File: rtl/ksa_swap_fsm_if.sv
// s_memory port bundle between the swap FSM (master) and the RAM/top-level mux (slave).
interface ksa_swap_fsm_if;
  import ksa_pkg::*;

  logic [BYTE_W-1:0] mem_addr;
  logic [BYTE_W-1:0] mem_wdata;
  logic [BYTE_W-1:0] mem_rdata;
  logic              mem_wren;
  logic              mem_own;

  modport master (output mem_addr, output mem_wdata, output mem_wren, output mem_own,
                  input mem_rdata);
  modport slave  (input mem_addr, input mem_wdata, input mem_wren, input mem_own,
                  output mem_rdata);
endinterface

// File: rtl/ksa_key_idx_ctr.sv
// Wrapping key-byte index counter: tracks i mod MOD without a divider.
module ksa_key_idx_ctr #(
  parameter int unsigned MOD = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       inc,
  output logic [2:0] idx
);

  localparam logic [2:0] LAST = 3'(MOD - 1);

  // Clear has priority so a new run always starts on key byte 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= 3'd0;
    end else if (clear) begin
      idx <= 3'd0;
    end else if (inc) begin
      idx <= (idx == LAST) ? 3'd0 : idx + 3'd1;
    end else begin
      idx <= idx;
    end
  end

endmodule

// File: rtl/ksa_swap_fsm.sv
// RC4 KSA swap-phase sequencer on the 256x8 s_memory (j += s[i] + key[i mod KEY_BYTES]; swap).
// Optional KSA_SKIP_SELF_SWAP_EN: skip both writes when i == j.
module ksa_swap_fsm
  import ksa_pkg::*;
#(
  parameter int KEY_BYTES = 3,
  parameter int RD_LAT    = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [8*KEY_BYTES-1:0] secret_key,
  ksa_swap_fsm_if.master         mem,
  output logic                   busy,
  output logic                   done
);

  localparam bit         HAS_WAIT  = (RD_LAT > 1);
  localparam logic [7:0] WAIT_LAST = (RD_LAT > 2) ? 8'(RD_LAT - 2) : 8'd0;

  ksa_swap_state_t        state_r;
  logic [7:0]             i_r, j_r, si_r, sj_r, wcnt_r;
  logic [8*KEY_BYTES-1:0] key_r;
  logic [7:0]             addr_r, wdata_r;
  logic                   wren_r, own_r, busy_r, done_r;

  logic [63:0] key_ext_s;
  logic [7:0]  j_sum_s;
  logic [2:0]  kidx_s;
  logic        last_i_s, self_s, adv_s, clear_s, inc_s;

  assign mem.mem_addr  = addr_r;
  assign mem.mem_wdata = wdata_r;
  assign mem.mem_wren  = wren_r;
  assign mem.mem_own   = own_r;
  assign busy          = busy_r;
  assign done          = done_r;

  // Key byte selection, next j and iteration-advance strobes
  always_comb begin
    key_ext_s                   = 64'd0;
    key_ext_s[63 -: 8*KEY_BYTES] = key_r;
    j_sum_s  = j_r + mem.mem_rdata + key_byte(key_ext_s, kidx_s);
    last_i_s = (i_r == 8'hFF);
    self_s   = (i_r == j_r);
    clear_s  = (state_r == ST_IDLE) && start;
`ifdef KSA_SKIP_SELF_SWAP_EN
    adv_s    = (state_r == ST_WR_J) || ((state_r == ST_CAP_J) && self_s);
`else
    adv_s    = (state_r == ST_WR_J);
`endif
    if (adv_s && !last_i_s) begin
      inc_s = 1'b1;
    end else begin
      inc_s = 1'b0;
    end
  end

  ksa_key_idx_ctr #(.MOD(KEY_BYTES)) u_kidx (
    .clk   (clk),
    .rst   (rst),
    .clear (clear_s),
    .inc   (inc_s),
    .idx   (kidx_s)
  );

  // Main sequencer; outputs are registered on entry to the state they belong to
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      i_r     <= 8'd0;
      j_r     <= 8'd0;
      si_r    <= 8'd0;
      sj_r    <= 8'd0;
      wcnt_r  <= 8'd0;
      key_r   <= '0;
      addr_r  <= 8'd0;
      wdata_r <= 8'd0;
      wren_r  <= 1'b0;
      own_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            key_r   <= secret_key;
            i_r     <= 8'd0;
            j_r     <= 8'd0;
            addr_r  <= 8'd0;
            busy_r  <= 1'b1;
            own_r   <= 1'b1;
            state_r <= ST_RD_I;
          end
        end
        ST_RD_I: begin
          wcnt_r  <= 8'd0;
          state_r <= HAS_WAIT ? ST_WT_I : ST_CAP_I;
        end
        ST_WT_I: begin
          if (wcnt_r == WAIT_LAST) begin
            state_r <= ST_CAP_I;
          end else begin
            wcnt_r <= wcnt_r + 8'd1;
          end
        end
        ST_CAP_I: begin
          si_r    <= mem.mem_rdata;
          j_r     <= j_sum_s;
          addr_r  <= j_sum_s;
          state_r <= ST_RD_J;
        end
        ST_RD_J: begin
          wcnt_r  <= 8'd0;
          state_r <= HAS_WAIT ? ST_WT_J : ST_CAP_J;
        end
        ST_WT_J: begin
          if (wcnt_r == WAIT_LAST) begin
            state_r <= ST_CAP_J;
          end else begin
            wcnt_r <= wcnt_r + 8'd1;
          end
        end
        ST_CAP_J: begin
          sj_r <= mem.mem_rdata;
`ifdef KSA_SKIP_SELF_SWAP_EN
          if (self_s && last_i_s) begin
            busy_r  <= 1'b0;
            own_r   <= 1'b0;
            done_r  <= 1'b1;
            state_r <= ST_FIN;
          end else if (self_s) begin
            i_r     <= i_r + 8'd1;
            addr_r  <= i_r + 8'd1;
            state_r <= ST_RD_I;
          end else begin
            addr_r  <= i_r;
            wdata_r <= mem.mem_rdata;
            wren_r  <= 1'b1;
            state_r <= ST_WR_I;
          end
`else
          addr_r  <= i_r;
          wdata_r <= mem.mem_rdata;
          wren_r  <= 1'b1;
          state_r <= ST_WR_I;
`endif
        end
        ST_WR_I: begin
          addr_r  <= j_r;
          wdata_r <= si_r;
          wren_r  <= 1'b1;
          state_r <= ST_WR_J;
        end
        ST_WR_J: begin
          wren_r <= 1'b0;
          if (last_i_s) begin
            busy_r  <= 1'b0;
            own_r   <= 1'b0;
            done_r  <= 1'b1;
            state_r <= ST_FIN;
          end else begin
            i_r     <= i_r + 8'd1;
            addr_r  <= i_r + 8'd1;
            state_r <= ST_RD_I;
          end
        end
        ST_FIN: begin
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          wren_r  <= 1'b0;
          own_r   <= 1'b0;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ksa_swap_fsm.sv
// Bench for ksa_swap_fsm: RD_LAT=1 and RD_LAT=3 instances against a plain RC4 KSA model.
// Honours KSA_SKIP_SELF_SWAP_EN when the build defines it.
module tb_ksa_swap_fsm;

  localparam int KB = 3;
`ifdef KSA_SKIP_SELF_SWAP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, start, load;
  logic [23:0] key;
  logic        busy1, done1, busy3, done3;

  always #5 clk = ~clk;

  ksa_swap_fsm_if m1();
  ksa_swap_fsm_if m3();

  ksa_swap_fsm #(.KEY_BYTES(KB), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .secret_key(key),
    .mem(m1.master), .busy(busy1), .done(done1));

  ksa_swap_fsm #(.KEY_BYTES(KB), .RD_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start), .secret_key(key),
    .mem(m3.master), .busy(busy3), .done(done3));

  // Synchronous-read RAM models with 1 and 3 cycles of read latency
  logic [7:0] ram1 [256];
  logic [7:0] ram3 [256];
  logic [7:0] pipe1;
  logic [7:0] pipe3 [3];

  always @(posedge clk) begin
    if (load) begin
      for (int k = 0; k < 256; k++) begin
        ram1[k] <= 8'(k);
        ram3[k] <= 8'(k);
      end
    end else begin
      if (m1.mem_wren) ram1[m1.mem_addr] <= m1.mem_wdata;
      if (m3.mem_wren) ram3[m3.mem_addr] <= m3.mem_wdata;
    end
    pipe1    <= ram1[m1.mem_addr];
    pipe3[0] <= ram3[m3.mem_addr];
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end

  assign m1.mem_rdata = pipe1;
  assign m3.mem_rdata = pipe3[2];

  // Observation: write logs, done pulses, busy cycles, mem_own vs busy
  int          cyc = 0;
  logic [15:0] log1 [$];
  logic [15:0] log3 [$];
  int done_n1 = 0, done_n3 = 0, done_c1 = 0, done_c3 = 0;
  int busy_n1 = 0, busy_n3 = 0, own_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (m1.mem_wren) log1.push_back({m1.mem_addr, m1.mem_wdata});
      if (m3.mem_wren) log3.push_back({m3.mem_addr, m3.mem_wdata});
      if (done1) begin done_n1 <= done_n1 + 1; done_c1 <= cyc; end
      if (done3) begin done_n3 <= done_n3 + 1; done_c3 <= cyc; end
      if (busy1) busy_n1 <= busy_n1 + 1;
      if (busy3) busy_n3 <= busy_n3 + 1;
      if ((busy1 !== m1.mem_own) || (busy3 !== m3.mem_own)) own_err <= own_err + 1;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference: textbook RC4 KSA, plus the write sequence and cycle counts it implies
  logic [7:0]  ms [256];
  logic [15:0] exp_w [$];
  int          exp_cyc1, exp_cyc3;

  task automatic model(input logic [23:0] kk);
    int         j, nself;
    logic [7:0] t, kb;
    exp_w.delete();
    j = 0;
    nself = 0;
    for (int k = 0; k < 256; k++) ms[k] = 8'(k);
    for (int i = 0; i < 256; i++) begin
      kb = kk[8*(KB-1-(i % KB)) +: 8];
      j  = (j + int'(ms[i]) + int'(kb)) % 256;
      if (SKIP && i == j) begin
        nself++;
      end else begin
        exp_w.push_back({8'(i), ms[j]});
        exp_w.push_back({8'(j), ms[i]});
      end
      t = ms[i]; ms[i] = ms[j]; ms[j] = t;
    end
    exp_cyc1 = 256*6  - 2*nself + 1;
    exp_cyc3 = 256*10 - 2*nself + 1;
  endtask

  int base1;

  task automatic load_ram();
    @(posedge clk); #1 load = 1'b1;
    @(posedge clk); #1 load = 1'b0;
  endtask

  task automatic run(input logic [23:0] kk, input bit poke);
    int s3, d1, d3, b1, b3, oe, sc, n;
    model(kk);
    key = kk;
    load_ram();
    base1 = log1.size(); s3 = log3.size();
    d1 = done_n1; d3 = done_n3; b1 = busy_n1; b3 = busy_n3; oe = own_err;
    start = 1'b1;
    sc = cyc;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    while ((done_n1 == d1 || done_n3 == d3) && n < 6000) begin
      @(posedge clk); #1;
      n++;
      if (poke && busy1 && busy3) start = ($urandom_range(0, 7) == 0);
      else start = 1'b0;
    end
    start = 1'b0;
    check("run_timeout", 32'(n < 6000), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    check("done_count_lat1", done_n1 - d1, 1);
    check("done_count_lat3", done_n3 - d3, 1);
    check("cycles_lat1", done_c1 - sc, exp_cyc1);
    check("cycles_lat3", done_c3 - sc, exp_cyc3);
    check("busy_cycles_lat1", busy_n1 - b1, exp_cyc1 - 1);
    check("busy_cycles_lat3", busy_n3 - b3, exp_cyc3 - 1);
    check("own_vs_busy", own_err - oe, 0);
    check("write_count_lat1", log1.size() - base1, exp_w.size());
    check("write_count_lat3", log3.size() - s3, exp_w.size());
    for (int w = 0; w < exp_w.size(); w++) begin
      if (base1 + w < log1.size()) check($sformatf("write1[%0d]", w), log1[base1 + w], exp_w[w]);
      if (s3 + w < log3.size())    check($sformatf("write3[%0d]", w), log3[s3 + w], exp_w[w]);
    end
    for (int k = 0; k < 256; k++) begin
      check($sformatf("ram1[%0d]", k), ram1[k], ms[k]);
      check($sformatf("ram3[%0d]", k), ram3[k], ms[k]);
    end
  endtask

  task automatic abort_run(input logic [23:0] kk);
    int  n, pairs;
    bit  prev;
    key = kk;
    load_ram();
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0; pairs = 0; prev = 1'b0;
    while (pairs < 101 && n < 6000) begin
      @(posedge clk); #1;
      n++;
      if (m1.mem_wren && prev) pairs++;
      prev = m1.mem_wren;
    end
    check("abort_reach_wr_j", 32'(pairs), 32'd101);
    #2 rst = 1'b1;
    #1;
    check("abort_wren", m1.mem_wren, 1'b0);
    check("abort_addr", m1.mem_addr, 8'd0);
    check("abort_wdata", m1.mem_wdata, 8'd0);
    check("abort_own", m1.mem_own, 1'b0);
    check("abort_busy", busy1, 1'b0);
    check("abort_wren_lat3", m3.mem_wren, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int ix;
    rst = 1'b1; start = 1'b0; load = 1'b0; key = 24'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_addr", m1.mem_addr, 8'd0);
    check("rst_wdata", m1.mem_wdata, 8'd0);
    check("rst_wren", m1.mem_wren, 1'b0);
    check("rst_own", m1.mem_own, 1'b0);
    check("rst_busy", busy1, 1'b0);
    check("rst_done", done1, 1'b0);
    check("rst_busy_lat3", busy3, 1'b0);
    rst = 1'b0;

    run(24'h000000, 1'b0);
    ix = SKIP ? 0 : 4;
    check("key0_iter2_wr_i", log1[base1 + ix],     16'h0203);
    check("key0_iter2_wr_j", log1[base1 + ix + 1], 16'h0302);

    run(24'h010203, 1'b0);
    check("k123_iter0_wr_i", log1[base1 + 0], 16'h0001);
    check("k123_iter0_wr_j", log1[base1 + 1], 16'h0100);
    check("k123_iter1_wr_i", log1[base1 + 2], 16'h0103);
    check("k123_iter1_wr_j", log1[base1 + 3], 16'h0300);

    run(24'h000249, 1'b1);
    run(24'($urandom), 1'b1);

    abort_run(24'h000249);
    run(24'($urandom), 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
